fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Parametrised instruction prefetch queue that replaces the single-register fetch stage in the core pipeline.
- Issues sequential word fetches to instruction memory over a req/ack handshake that tolerates variable latency.
- Buffers up to DEPTH {pc, instruction} entries and presents them to decode with valid/ready.
- On a taken jump/branch it flushes all buffered entries and redirects fetch to the target.

Parameters:
- DEPTH, 4: queue entries; power of two, >= 2.
- ADDR_W, 30: word-address width of the PC and of imem_address.
- RESET_PC, 0: word address fetched first after reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- sync_rst  input  1  reset, synchronous, active-high.
- clk_en  input  1  global enable; when low, all state holds.
- jmp  input  1  redirect request from the memory stage (taken branch/jump/ecall).
- jmp_target  input  ADDR_W  word address to fetch after a redirect.
- imem_req  output  1  fetch request to instruction memory.
- imem_address  output  ADDR_W  word address of the current request.
- imem_ack  input  1  memory accepted the request; imem_data valid this cycle.
- imem_data  input  32  fetched instruction word, little endian.
- out_valid  output  1  head entry is valid.
- out_inst  output  32  head instruction.
- out_pc  output  ADDR_W  word address of the head instruction.
- out_ready  input  1  decode consumes the head this cycle.

Behaviour:
- State: fetch_pc (ADDR_W), storage array[DEPTH] of {pc, inst}, rd_ptr, wr_ptr (log2 DEPTH bits, wrap naturally), count (0..DEPTH).
- Reset (sync_rst high at a rising edge): fetch_pc=RESET_PC, rd_ptr=wr_ptr=0, count=0. Reset overrides every other input, including jmp and ack. Storage contents are don't-care.
- Reset outputs: out_valid=0, imem_req=0, imem_address=RESET_PC. out_inst/out_pc are don't-care while out_valid=0.
- imem_req = clk_en && !sync_rst && !jmp && (count < DEPTH). It is combinational; no request is issued while the queue is full.
- imem_address = fetch_pc (registered). It is held until ack, unless a redirect occurs.
- Push = imem_req && imem_ack. On push:
  - storage[wr_ptr] <= {fetch_pc, imem_data}
  - wr_ptr++
  - fetch_pc <= fetch_pc+1, modulo 2^ADDR_W; wrap from all-ones to 0 is legal.
- Pop = clk_en && !jmp && out_valid && out_ready. On pop: rd_ptr++.
- count updates as +push -pop. Push and pop in the same cycle leave count unchanged.
- No fall-through: an ack in cycle N gives out_valid=1 at N+1 at the earliest. Max throughput is 1 instruction/cycle with a same-cycle-ack memory.
- out_valid = (count != 0). out_inst/out_pc come combinationally from storage[rd_ptr].
- Redirect: jmp high with clk_en high means:
  - Any ack in that cycle is discarded.
  - No pop occurs.
  - Next cycle: count=0, rd_ptr=wr_ptr=0, fetch_pc=jmp_target.
  - The first post-redirect request is issued the cycle after jmp.
- jmp with clk_en low is ignored.
- Requests are abortable. Memory must treat a change of imem_address, or imem_req dropping, as cancelling the outstanding request.
- Boundaries:
  - Full: imem_req=0; a pop in that cycle does not enable a same-cycle push.
  - Empty: no pop, out_ready is ignored.
  - clk_en low: pointers, count and fetch_pc hold; imem_req=0; outputs stay stable.

Optional Feature:
- Macro: FETCH_QUEUE_BYTESWAP_EN.
- Defined: imem_data is byte-reversed on push ({[7:0],[15:8],[23:16],[31:24]}). Decode receives the adjusted instruction word.
- Undefined: imem_data is stored and presented unchanged; swapping stays in the core wrapper.
- Timing and handshake are identical in both builds.

Decomposition:
- Package fetch_pkg: localparam INST_W=32; function clog2-based PTR_W helper; byte-swap function bswap32 used by the optional feature.
- One sub-module: fetch_queue_mem. DEPTH x (ADDR_W+32) register array with one write port and one asynchronous read port. Pointer/count control and fetch_pc stay in fetch_queue.

Test Plan:
- Reset, then memory with same-cycle ack, out_ready=1 -> imem_address 0,1,2,...; out_pc=0 at cycle 2 after reset release, then one per cycle; out_inst matches memory.
- out_ready=0, DEPTH=4 -> exactly 4 pushes; then imem_req=0 and imem_address=4 held; raising out_ready gives pcs 0..3 in order, and imem_req rises the cycle after the first pop.
- Queue holding 3 entries, jmp=1 with jmp_target=0x100 and same-cycle ack -> ack dropped; next cycle out_valid=0 and imem_address=0x100; first valid out_pc=0x100.
- Memory acking every 3rd cycle -> out_valid gaps with no duplicated or skipped pc; clk_en low for 5 cycles mid-run freezes all outputs.
- RESET_PC=30'h3FFFFFFE -> fetched addresses 0x3FFFFFFE, 0x3FFFFFFF, 0x0.
- FETCH_QUEUE_BYTESWAP_EN defined, imem_data=0x13000000 -> out_inst=0x00000013; undefined -> 0x13000000.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_pkg : shared constants and helpers for the instruction fetch queue    |
// | Rev 1.0   : initial release                                                 |
// +----------------------------------------------------------------------------+
package fetch_pkg;

   localparam int INST_W = 32;

   // Pointer width for a power-of-two queue; never narrower than one bit.
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic logic [INST_W-1:0] bswap32(input logic [INST_W-1:0] d);
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_queue_mem : DEPTH x WIDTH register array, one write, async read port  |
// | Rev 1.0         : initial release                                           |
// +----------------------------------------------------------------------------+
module fetch_queue_mem
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 62
) (
   input  logic                    clk,
   input  logic                    we,
   input  logic [ptr_w(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]        wdata,
   input  logic [ptr_w(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]        rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // Contents are don't-care after reset, so the array carries no reset.
   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_queue : instruction prefetch queue with req/ack fetch and redirect    |
// |               Optional build macro: FETCH_QUEUE_BYTESWAP_EN                 |
// | Rev 1.0     : initial release                                               |
// +----------------------------------------------------------------------------+
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int                DEPTH    = 4,
   parameter int                ADDR_W   = 30,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              sync_rst,
   input  logic              clk_en,
   input  logic              jmp,
   input  logic [ADDR_W-1:0] jmp_target,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_address,
   input  logic              imem_ack,
   input  logic [INST_W-1:0] imem_data,
   output logic              out_valid,
   output logic [INST_W-1:0] out_inst,
   output logic [ADDR_W-1:0] out_pc,
   input  logic              out_ready
);

   localparam int              PTR_W   = ptr_w(DEPTH);
   localparam int              ENTRY_W = ADDR_W + INST_W;
   localparam logic [PTR_W:0]  c_full  = (PTR_W+1)'(DEPTH);

   logic [ADDR_W-1:0]  r_fetch_pc;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W:0]     r_count;

   logic               w_push;
   logic               w_pop;
   logic [INST_W-1:0]  w_inst;
   logic [ENTRY_W-1:0] w_rd_entry;

`ifdef FETCH_QUEUE_BYTESWAP_EN
   assign w_inst = bswap32(imem_data);
`else
   assign w_inst = imem_data;
`endif

   // A full queue blocks the request even if decode pops this cycle.
   assign imem_req     = clk_en && !sync_rst && !jmp && (r_count != c_full);
   assign imem_address = r_fetch_pc;
   assign out_valid    = (r_count != '0);

   assign w_push = imem_req && imem_ack;
   assign w_pop  = clk_en && !jmp && out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (sync_rst) begin
         r_fetch_pc <= RESET_PC;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
      end else if (clk_en) begin
         if (jmp) begin
            r_fetch_pc <= jmp_target;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
         end else begin
            if (w_push) begin
               r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
               r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
         end
      end
   end

   fetch_queue_mem #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_mem (
      .clk   (clk),
      .we    (w_push),
      .waddr (r_wr_ptr),
      .wdata ({r_fetch_pc, w_inst}),
      .raddr (r_rd_ptr),
      .rdata (w_rd_entry)
   );

   assign out_pc   = w_rd_entry[ENTRY_W-1:INST_W];
   assign out_inst = w_rd_entry[INST_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_queue : scoreboard bench for fetch_queue against a queue model     |
// | Rev 1.0        : initial release                                            |
// +----------------------------------------------------------------------------+
module tb_fetch_queue;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = 30;
   localparam logic [ADDR_W-1:0] RESET_PC = '0;
   localparam logic [ADDR_W-1:0] c_swap_pc = 30'h55;
`ifdef FETCH_QUEUE_BYTESWAP_EN
   localparam logic [31:0] c_swap_inst = 32'h0000_0013;
`else
   localparam logic [31:0] c_swap_inst = 32'h1300_0000;
`endif

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [31:0]       inst;
   } ent_t;

   logic              clk = 1'b0;
   logic              sync_rst, clk_en, jmp, imem_ack, out_ready;
   logic [ADDR_W-1:0] jmp_target;
   logic              imem_req, out_valid;
   logic [ADDR_W-1:0] imem_address, out_pc;
   logic [31:0]       imem_data, out_inst;

   int n_checks = 0;
   int n_errors = 0;

   fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
      .clk          (clk),
      .sync_rst     (sync_rst),
      .clk_en       (clk_en),
      .jmp          (jmp),
      .jmp_target   (jmp_target),
      .imem_req     (imem_req),
      .imem_address (imem_address),
      .imem_ack     (imem_ack),
      .imem_data    (imem_data),
      .out_valid    (out_valid),
      .out_inst     (out_inst),
      .out_pc       (out_pc),
      .out_ready    (out_ready)
   );

   always #5 clk = ~clk;

   // Instruction memory contents as a pure function of the word address.
   function automatic logic [31:0] mem_fn(input logic [ADDR_W-1:0] a);
      if (a == c_swap_pc) return 32'h1300_0000;
      return (32'(a) * 32'h9E37_79B1) ^ 32'hA5C3_0F1E;
   endfunction

   function automatic logic [31:0] exp_inst(input logic [ADDR_W-1:0] a);
      logic [31:0] d;
      d = mem_fn(a);
`ifdef FETCH_QUEUE_BYTESWAP_EN
      d = {d[7:0], d[15:8], d[23:16], d[31:24]};
`endif
      return d;
   endfunction

   assign imem_data = mem_fn(imem_address);

   // Reference model: expected queue contents and next fetch address.
   ent_t              exp_q[$];
   logic [ADDR_W-1:0] m_pc;
   bit                m_known = 1'b0;
   bit                m_push  = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   always @(posedge clk) begin
      if (sync_rst) begin
         m_pc = RESET_PC;
         exp_q.delete();
         m_known = 1'b1;
      end else if (clk_en && m_known) begin
         if (jmp) begin
            exp_q.delete();
            m_pc = jmp_target;
         end else if (m_push) begin
            exp_q.push_back('{pc: m_pc, inst: exp_inst(m_pc)});
            m_pc = m_pc + 1'b1;
         end
      end
   end

   // Monitor: compares the DUT against the model away from the active edge.
   always @(negedge clk) begin
      bit   exp_req;
      ent_t e;
      m_push = 1'b0;
      if (m_known) begin
         exp_req = clk_en && !sync_rst && !jmp && (exp_q.size() < DEPTH);
         check("imem_req", 64'(imem_req), 64'(exp_req));
         check("imem_address", 64'(imem_address), 64'(m_pc));
         check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
         m_push = exp_req && imem_ack;
         if (!sync_rst && clk_en && !jmp && out_ready && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("out_pc", 64'(out_pc), 64'(e.pc));
            check("out_inst", 64'(out_inst), 64'(e.inst));
            if (e.pc == c_swap_pc)
               check("swap_inst", 64'(out_inst), 64'(c_swap_inst));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input bit en, input bit j, input logic [ADDR_W-1:0] tgt,
                         input bit ack, input bit rdy);
      clk_en = en; jmp = j; jmp_target = tgt; imem_ack = ack; out_ready = rdy;
   endtask

   initial begin
      sync_rst = 1'b1;
      set_in(1, 0, '0, 1, 1);
      repeat (2) cyc();
      sync_rst = 1'b0;
      // Streaming with same-cycle ack.
      repeat (20) cyc();
      // Fill to full with decode stalled, then drain.
      out_ready = 1'b0;
      repeat (8) cyc();
      out_ready = 1'b1;
      repeat (6) cyc();
      // Flush, build three entries, then redirect while acking.
      set_in(1, 1, 30'h200, 1, 0);
      cyc();
      jmp = 1'b0;
      repeat (3) cyc();
      set_in(1, 1, 30'h100, 1, 0);
      cyc();
      set_in(1, 0, '0, 1, 1);
      repeat (10) cyc();
      // Slow memory with a clock-enable freeze in the middle.
      for (int i = 0; i < 30; i++) begin
         imem_ack  = (i % 3 == 2);
         clk_en    = !(i >= 12 && i < 17);
         out_ready = (i % 5 != 4);
         cyc();
      end
      // Address wrap through all-ones.
      set_in(1, 1, 30'h3FFF_FFFE, 1, 1);
      cyc();
      jmp = 1'b0;
      repeat (6) cyc();
      // Known instruction word to exercise the byte-order build option.
      set_in(1, 1, c_swap_pc, 1, 1);
      cyc();
      jmp = 1'b0;
      repeat (5) cyc();
      // Randomized traffic, including occasional resets.
      for (int i = 0; i < 2000; i++) begin
         set_in(($urandom % 16) != 0, ($urandom % 25) == 0, ADDR_W'($urandom),
                ($urandom % 3) != 0, ($urandom % 4) != 0);
         sync_rst = (($urandom % 300) == 0);
         cyc();
      end
      sync_rst = 1'b0;
      repeat (3) cyc();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
